exp_horner_sched: RTL and testbench



---
 rtl/exp_horner_sched.sv | 113 +++++++++++
 tb/tb_exp_horner_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_horner_sched.sv
// exp_horner_sched: round-robin scheduler sharing an external multiplier/adder to evaluate exp(x) by Horner, optional EXP_HORNER_SCHED_STATS_EN counters
module exp_horner_sched #(
    parameter int NREQ = 4,
    parameter int WIDTHIN = 16,
    parameter int WIDTHOUT = 32,
    parameter logic [WIDTHIN-1:0] A0 = 16'h4000,
    parameter logic [WIDTHIN-1:0] A1 = 16'h4000,
    parameter logic [WIDTHIN-1:0] A2 = 16'h2000,
    parameter logic [WIDTHIN-1:0] A3 = 16'h0AAA,
    parameter logic [WIDTHIN-1:0] A4 = 16'h02AA,
    parameter logic [WIDTHIN-1:0] A5 = 16'h0088,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTHIN-1:0] req_x,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTHOUT-1:0]     rsp_y,
    output logic [WIDTHOUT-1:0]     mult_a,
    output logic [WIDTHIN-1:0]      mult_b,
    input  logic [WIDTHOUT-1:0]     mult_res,
    output logic [WIDTHOUT-1:0]     add_a,
    output logic [WIDTHIN-1:0]      add_b,
    input  logic [WIDTHOUT-1:0]     add_res,
    output logic                    busy
`ifdef EXP_HORNER_SCHED_STATS_EN
   ,output logic [15:0]             stat_done,
    output logic [15:0]             stat_stall
`endif
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state;
    logic [WIDTHOUT-1:0] acc;
    logic [WIDTHIN-1:0] x_reg;
    logic [IDW-1:0] id_reg, rr_ptr, win, idx;
    logic [2:0] stage;
    logic found, accept;
    logic [WIDTHIN-1:0] xs [NREQ];
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign xs[g] = req_x[g*WIDTHIN +: WIDTHIN];
    end
    // round-robin search starting just after the last granted requester
    always_comb begin
        win = '0;
        idx = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end
    assign accept = found && (state == IDLE || (state == DONE && rsp_ready));
    assign req_ready = (accept && !reset) ? (NREQ'(1) << win) : '0;
    // accept a new operand, step the Horner stages, retire the response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc <= '0;
            x_reg <= '0;
            id_reg <= '0;
            stage <= '0;
            rr_ptr <= IDW'(NREQ - 1);
        end else if (accept) begin
            x_reg <= xs[win];
            id_reg <= win;
            rr_ptr <= win;
            stage <= 3'd1;
            state <= CALC;
        end else if (state == CALC) begin
            acc <= add_res;
            stage <= (stage == 3'd5) ? 3'd0 : stage + 3'd1;
            if (stage == 3'd5) state <= DONE;
        end else if (state == DONE && rsp_ready) begin
            state <= IDLE;
        end
    end
    // drive the shared arithmetic units only while a stage is in flight
    always_comb begin
        mult_a = '0;
        mult_b = '0;
        add_a = '0;
        add_b = '0;
        if (state == CALC) begin
            mult_a = (stage == 3'd1) ? WIDTHOUT'({A5, 11'b0}) : acc;
            mult_b = x_reg;
            add_a = mult_res;
            add_b = (stage == 3'd1) ? A4 : (stage == 3'd2) ? A3 : (stage == 3'd3) ? A2 : (stage == 3'd4) ? A1 : A0;
        end
    end
    assign rsp_valid = state == DONE;
    assign rsp_y = rsp_valid ? acc : '0;
    assign rsp_id = id_reg;
    assign busy = state != IDLE;
`ifdef EXP_HORNER_SCHED_STATS_EN
    // count completed responses (wrapping) and backpressured DONE cycles (saturating)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_done <= '0;
            stat_stall <= '0;
        end else if (rsp_valid) begin
            if (rsp_ready) stat_done <= stat_done + 16'd1;
            else if (stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_exp_horner_sched.sv
// tb_exp_horner_sched: randomized scoreboard bench for exp_horner_sched with external mult/add models
module tb_exp_horner_sched;
    localparam int NREQ = 4;
    localparam int IDW = 2;
    localparam logic [15:0] C [6] = '{16'h4000, 16'h4000, 16'h2000, 16'h0AAA, 16'h02AA, 16'h0088};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ-1:0] req_ready;
    logic [NREQ*16-1:0] req_x = '0;
    logic rsp_valid;
    logic rsp_ready = 1'b1;
    logic [IDW-1:0] rsp_id;
    logic [31:0] rsp_y, mult_a, mult_res, add_a, add_res;
    logic [15:0] mult_b, add_b;
    logic busy;
    logic [47:0] prod;
`ifdef EXP_HORNER_SCHED_STATS_EN
    logic [15:0] stat_done, stat_stall;
`endif

    exp_horner_sched dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .mult_a(mult_a), .mult_b(mult_b), .mult_res(mult_res),
        .add_a(add_a), .add_b(add_b), .add_res(add_res),
        .busy(busy)
`ifdef EXP_HORNER_SCHED_STATS_EN
       ,.stat_done(stat_done), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // external arithmetic units
    assign prod = 48'(mult_a) * 48'(mult_b);
    assign mult_res = prod[45:14];
    assign add_res = add_a + {5'b0, add_b, 11'b0};

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0] y;
    } exp_t;
    exp_t exp_q[$];
    int got_ids[$];
    int n_cmp = 0;
    int n_err = 0;
    int m_cnt = 0;
    int m_ptr = NREQ - 1;
    logic [15:0] m_done = '0;
    logic [15:0] m_stall = '0;
    logic [31:0] last_y = '0;
    logic [IDW-1:0] last_id = '0;
    logic [NREQ-1:0] hs = '0;

    function automatic logic [31:0] ref_exp(input logic [15:0] x);
        logic [63:0] y;
        y = 64'(C[5]) << 11;
        for (int k = 4; k >= 0; k--) begin
            y = (((y * 64'(x)) >> 14) & 64'hFFFF_FFFF) + (64'(C[k]) << 11);
            y = y & 64'hFFFF_FFFF;
        end
        return y[31:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired at %0t", nm, $time);
    endtask

    // request-side model: predicts grants, busy/valid timing and pushes expected responses
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_rsp_y", rsp_y, 0);
`ifdef EXP_HORNER_SCHED_STATS_EN
            chk("rst_stat_done", 32'(stat_done), 0);
            chk("rst_stat_stall", 32'(stat_stall), 0);
`endif
            m_cnt = 0;
            m_ptr = NREQ - 1;
            m_done = '0;
            m_stall = '0;
            exp_q.delete();
        end else begin
            logic allow, found;
            int w;
            logic [NREQ-1:0] exp_rdy;
            allow = (m_cnt == 0) || (m_cnt == 6 && rsp_ready);
            found = 1'b0;
            w = 0;
            for (int k = 1; k <= NREQ; k++) begin
                if (!found && req_valid[(m_ptr + k) % NREQ]) begin
                    found = 1'b1;
                    w = (m_ptr + k) % NREQ;
                end
            end
            exp_rdy = '0;
            if (allow && found) exp_rdy[w] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(m_cnt != 0));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_cnt == 6));
`ifdef EXP_HORNER_SCHED_STATS_EN
            chk("stat_done", 32'(stat_done), 32'(m_done));
            chk("stat_stall", 32'(stat_stall), 32'(m_stall));
`endif
            if (m_cnt == 6 && rsp_ready) m_done = m_done + 16'd1;
            if (m_cnt == 6 && !rsp_ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (allow && found) begin
                exp_q.push_back('{id: IDW'(w), y: ref_exp(req_x[w*16 +: 16])});
                m_ptr = w;
                m_cnt = 1;
            end else if (m_cnt == 6 && rsp_ready) begin
                m_cnt = 0;
            end else if (m_cnt != 0 && m_cnt != 6) begin
                m_cnt++;
            end
        end
    end

    // response monitor: compares every presented result against the queue head
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (exp_q.size() == 0) begin
                timeout("rsp_unexpected");
            end else begin
                chk("rsp_y", rsp_y, exp_q[0].y);
                chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
                if (rsp_ready) begin
                    last_y = rsp_y;
                    last_id = rsp_id;
                    got_ids.push_back(int'(rsp_id));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #2;
        req_valid = req_valid & ~hs;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [15:0] x);
        req_x[i*16 +: 16] = x;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_hs(input int i);
        for (int n = 0; n < 50; n++) begin
            tick();
            if (hs[i]) return;
        end
        timeout("wait_hs");
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (m_cnt == 0 && exp_q.size() == 0) return;
            tick();
        end
        timeout("drain");
    endtask

    function automatic logic [15:0] pick_x();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h4000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        set_req(0, 16'h0000);
        wait_hs(0);
        drain();
        chk("x0_y", last_y, 32'h0200_0000);
        chk("x0_id", 32'(last_id), 0);
        set_req(2, 16'h4000);
        wait_hs(2);
        drain();
        chk("x1_y", last_y, 32'h056E_E000);
        chk("x1_id", 32'(last_id), 2);

        req_valid = '1;
        for (int i = 0; i < NREQ; i++) req_x[i*16 +: 16] = pick_x();
        rsp_ready = 1'b1;
        do_reset();
        got_ids.delete();
        for (int n = 0; n < 200 && got_ids.size() < 6; n++) begin
            tick();
            for (int i = 0; i < NREQ; i++) if (hs[i]) set_req(i, pick_x());
        end
        drain();
        if (got_ids.size() < 6) timeout("fair_count");
        else for (int k = 0; k < 6; k++) chk("fair_order", 32'(got_ids[k]), 32'(k % NREQ));

        req_valid = '0;
        do_reset();
        rsp_ready = 1'b0;
        set_req(1, pick_x());
        wait_hs(1);
        set_req(1, pick_x());
        begin
            int n;
            for (n = 0; n < 20; n++) begin
                @(negedge clk);
                if (rsp_valid) break;
            end
            if (n == 20) timeout("bp_wait_done");
        end
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2;
        rsp_ready = 1'b1;
        wait_hs(1);
`ifdef EXP_HORNER_SCHED_STATS_EN
        @(negedge clk);
        chk("bp_stat_stall", 32'(stat_stall), 10);
        chk("bp_stat_done", 32'(stat_done), 1);
`endif
        drain();

        set_req(1, pick_x());
        wait_hs(1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        got_ids.delete();
        set_req(0, pick_x());
        set_req(3, pick_x());
        for (int n = 0; n < 60 && req_valid != '0; n++) tick();
        drain();
        if (got_ids.size() < 2) timeout("rst_calc_count");
        else begin
            chk("rst_calc_first", 32'(got_ids[0]), 0);
            chk("rst_calc_second", 32'(got_ids[1]), 3);
        end

        for (int n = 0; n < 600; n++) begin
            rsp_ready = $urandom_range(0, 3) != 0;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) set_req(i, pick_x());
                else if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
            end
            tick();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
